aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Parametrised AES key-schedule unit for the byte-serial AES datapath.
- Accepts a 128/192/256-bit cipher key one byte per cycle and expands it iteratively, one 32-bit word per cycle, per FIPS-197.
- Stores all round keys and serves any round key as a 128-bit word on a registered read port.
- Replaces the fixed 128-bit round-key generation and storage; the AES controller addresses it by round number for both encrypt and decrypt.

Parameters:
- KEY_BITS, 128, cipher key length: 128, 192 or 256. Any other value triggers an elaboration-time $error.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; aborts any operation and enters LOAD.
- key_in  input  8  key byte; the first byte is key byte 0.
- key_valid  input  1  key_in is valid this cycle.
- key_ready  output  1  high in LOAD; a byte is accepted when key_valid && key_ready.
- busy  output  1  high in LOAD or EXPAND.
- done  output  1  one-cycle pulse when expansion completes.
- keys_valid  output  1  level; all round keys are stored and readable.
- rd_round  input  4  round index, 0..NR.
- rd_key  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}; key byte 0 in bits [127:120].

Behaviour:
- Derived constants: NK = KEY_BITS/32 (4, 6 or 8); NR = NK+6; NW = 4*(NR+1) (44, 52 or 60).
- Reset: state IDLE; key_ready, busy, done, keys_valid and rd_key all 0; byte and word counters cleared. Key memory contents are don't-care but unreadable, because keys_valid = 0.
- IDLE: waits for start.
- start in any state: next state is LOAD, keys_valid <= 0, counters cleared. A start during EXPAND aborts the expansion with no done pulse.
- LOAD: key_ready = 1. Each accepted byte shifts into the word being assembled, MSB first. Every 4th byte writes w[j] to memory and to an NK-word sliding window.
  - When byte 4*NK-1 is accepted, the next state is EXPAND with i = NK.
  - Bytes with key_valid = 0 stall LOAD indefinitely.
- EXPAND: one word per cycle, i = NK..NW-1.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp. The result is written to memory and the window shifts.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36, generated by xtime from 01 (not a table indexed beyond 10).
  - Duration is NW-NK cycles: 40 for 128-bit, 46 for 192-bit, 52 for 256-bit.
  - The i mod NK computation uses a wrap counter, not a divider.
- Completion: in the cycle after w[NW-1] is written, done = 1 for one cycle, keys_valid = 1, and state READY.
- READY: holds until start. key_ready = 0; key_valid is ignored.
- Read port: rd_key is registered and has 1-cycle latency from rd_round. It is valid only while keys_valid = 1.
  - rd_round > NR returns 128'h0.
  - Reads while keys_valid = 0 return 128'h0.
- Total latency from start to done with continuous key_valid: 4*NK + (NW-NK) + 1 cycles.
- rst asserted mid-LOAD or mid-EXPAND: same as reset; no done pulse.

Optional Feature:
- Macro AES_KEYEXP_INVMIX_EN.
- Defined: adds output rd_key_dec [127:0] with the same latency as rd_key.
  - For 1 <= rd_round <= NR-1, it carries InvMixColumns applied to each 32-bit column of the round key (FIPS-197 equivalent inverse cipher).
  - For rounds 0 and NR it equals rd_key.
  - Out-of-range or invalid reads return 0.
- Undefined: the port and its logic are absent, and the key schedule is unchanged.

Decomposition:
- aes_pkg holds the S-box constant array, function sub_word, function xtime, and the key_len_t enum (KEY128/KEY192/KEY256).
- aes_pkg also holds functions nk_of(KEY_BITS) and nr_of(KEY_BITS), and, when used, function inv_mix_col.
- One sub-module, aes_key_word_gen: combinational next-word logic.
  - Inputs: w[i-1], w[i-NK], rot_sub flag, sub_only flag, rcon.
  - Output: w[i].
- The FSM, counters, window, memory and read port stay in the top.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c streamed continuously:
  - done occurs 57 cycles after start.
  - rd_round = 1 gives a0fafe1788542cb123a339392a6c7605.
  - rd_round = 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done occurs 71 cycles after start.
  - rd_round = 12 gives e98ba06f448c773c8ecc720401002202.
  - rd_round = 13 gives 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, with key_valid deasserted every other cycle:
  - rd_round = 14 gives fe4890d1e6188d0b046df344706c631e.
  - rd_round = 0 gives the first 16 key bytes.
- Abort: start issued at EXPAND cycle 10, then a new 128-bit key:
  - No done pulse for the aborted run.
  - keys_valid stays 0 until the new run's done.
  - The new keys match the reference model.
- Reset during LOAD after 7 bytes:
  - The next cycle shows busy = 0, key_ready = 0, keys_valid = 0, rd_key = 0.
  - A subsequent full load produces correct keys.
- With AES_KEYEXP_INVMIX_EN, AES-128 FIPS key:
  - rd_key_dec for round 0 and round 10 equals rd_key.
  - rd_key_dec for round 5 equals InvMixColumns(rd_key) from the model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule unit: S-box, GF(2^8) helpers,
// key-length decode and the optional InvMixColumns helper.
// Optional feature macro: AES_KEYEXP_INVMIX_EN (adds inv_mix_col).
package aes_pkg;

  typedef enum logic [1:0] {KEY128 = 2'd0, KEY192 = 2'd1, KEY256 = 2'd2} key_len_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic key_len_t key_len_of(input int key_bits);
    key_len_t len;
    case (key_bits)
      192:     len = KEY192;
      256:     len = KEY256;
      default: len = KEY128;
    endcase
    return len;
  endfunction

  function automatic int nk_of(input int key_bits);
    int nk;
    case (key_len_of(key_bits))
      KEY192:  nk = 6;
      KEY256:  nk = 8;
      default: nk = 4;
    endcase
    return nk;
  endfunction

  function automatic int nr_of(input int key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

`ifdef AES_KEYEXP_INVMIX_EN
  // InvMixColumns on one column; byte 0 of the column sits in bits [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a     = c[31-8*k -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational next-word step of the AES key schedule:
// w[i] = w[i-NK] ^ f(w[i-1]), where f is RotWord/SubWord/Rcon, SubWord only, or identity.
module aes_key_word_gen
  import aes_pkg::*;
(
  input  logic [31:0] w_prev_i,
  input  logic [31:0] w_back_i,
  input  logic        rot_sub_i,
  input  logic        sub_only_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] w_next_o
);

  logic [31:0] temp_s;

  // Select the transform of w[i-1] and fold in w[i-NK].
  always_comb begin
    temp_s = w_prev_i;
    if (rot_sub_i) begin
      temp_s = sub_word({w_prev_i[23:0], w_prev_i[31:24]}) ^ {rcon_i, 24'h000000};
    end else if (sub_only_i) begin
      temp_s = sub_word(w_prev_i);
    end else begin
      temp_s = w_prev_i;
    end
    w_next_o = w_back_i ^ temp_s;
  end

endmodule

// File: rtl/aes_key_expander.sv
// AES key-schedule unit: byte-serial key load, one-word-per-cycle expansion,
// round-key storage and a registered 128-bit round-key read port.
// Optional feature macro: AES_KEYEXP_INVMIX_EN (adds rd_key_dec for the
// equivalent inverse cipher).
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
`ifdef AES_KEYEXP_INVMIX_EN
  ,
  output logic [127:0] rd_key_dec
`endif
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_LAST  = 6'(NK - 1);
  localparam logic [5:0] NW_LAST  = 6'(NW - 1);
  localparam logic [2:0] MOD_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic       IS_256   = (NK == 8);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_READY  = 2'd3;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;      // earlier bytes of the word being assembled
  logic [5:0]  idx_q, idx_d;        // index of the next word to be written
  logic [2:0]  mod_q, mod_d;        // idx mod NK, kept as a wrap counter
  logic [7:0]  rcon_q, rcon_d;
  logic        done_q, done_d;
  logic        kv_q, kv_d;
  logic        wr_en_s;
  logic [31:0] wr_word_s;
  logic [31:0] gen_word_s;
  logic        rot_sub_s, sub_only_s;
  logic [31:0] mem_q [NW];
  logic [31:0] win_q [NK];          // win_q[0] = w[i-NK], win_q[NK-1] = w[i-1]
  logic        rd_ok_s;
  logic [5:0]  rd_base_s;
  logic [127:0] rd_word_s;
  logic [127:0] rd_key_q;

  assign rot_sub_s  = (mod_q == 3'd0);
  assign sub_only_s = IS_256 && (mod_q == 3'd4);

  aes_key_word_gen u_word_gen (
    .w_prev_i   (win_q[NK-1]),
    .w_back_i   (win_q[0]),
    .rot_sub_i  (rot_sub_s),
    .sub_only_i (sub_only_s),
    .rcon_i     (rcon_q),
    .w_next_o   (gen_word_s)
  );

  // Next-state logic for the load/expand sequencer.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    idx_d      = idx_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    kv_d       = kv_q;
    wr_en_s    = 1'b0;
    wr_word_s  = 32'h0;
    if (start) begin
      state_d    = S_LOAD;
      byte_cnt_d = 2'd0;
      idx_d      = 6'd0;
      mod_d      = 3'd0;
      rcon_d     = 8'h01;
      kv_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          if (key_valid) begin
            word_d     = {word_q[15:0], key_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_en_s   = 1'b1;
              wr_word_s = {word_q, key_in};
              idx_d     = idx_q + 6'd1;
              if (idx_q == NK_LAST) begin
                state_d = S_EXPAND;
                mod_d   = 3'd0;
                rcon_d  = 8'h01;
              end else begin
                state_d = S_LOAD;
              end
            end else begin
              wr_en_s = 1'b0;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_EXPAND: begin
          wr_en_s   = 1'b1;
          wr_word_s = gen_word_s;
          idx_d     = idx_q + 6'd1;
          if (mod_q == MOD_LAST) begin
            mod_d = 3'd0;
          end else begin
            mod_d = mod_q + 3'd1;
          end
          if (rot_sub_s) begin
            rcon_d = xtime(rcon_q);
          end else begin
            rcon_d = rcon_q;
          end
          if (idx_q == NW_LAST) begin
            state_d = S_READY;
            done_d  = 1'b1;
            kv_d    = 1'b1;
          end else begin
            state_d = S_EXPAND;
          end
        end
        S_READY: state_d = S_READY;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer state, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'h0;
      idx_q      <= 6'd0;
      mod_q      <= 3'd0;
      rcon_q     <= 8'h01;
      done_q     <= 1'b0;
      kv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
      kv_q       <= kv_d;
    end
  end

  // Key memory and sliding window; contents are only readable once kv_q is set.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_q] <= wr_word_s;
      for (int k = 0; k < NK - 1; k++) begin
        win_q[k] <= win_q[k+1];
      end
      win_q[NK-1] <= wr_word_s;
    end
  end

  // Round-key lookup; out-of-range rounds are steered to word 0 and masked later.
  always_comb begin
    rd_ok_s   = kv_q && (rd_round <= NR_IDX);
    rd_base_s = (rd_round <= NR_IDX) ? {rd_round, 2'b00} : 6'd0;
    rd_word_s = {mem_q[rd_base_s], mem_q[rd_base_s + 6'd1],
                 mem_q[rd_base_s + 6'd2], mem_q[rd_base_s + 6'd3]};
  end

  // Registered round-key read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q <= 128'h0;
    end else if (rd_ok_s) begin
      rd_key_q <= rd_word_s;
    end else begin
      rd_key_q <= 128'h0;
    end
  end

`ifdef AES_KEYEXP_INVMIX_EN
  logic [127:0] rd_key_dec_q;

  // Decryption-form round key: InvMixColumns on inner rounds, plain at the ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_dec_q <= 128'h0;
    end else if (!rd_ok_s) begin
      rd_key_dec_q <= 128'h0;
    end else if (rd_round == 4'd0 || rd_round == NR_IDX) begin
      rd_key_dec_q <= rd_word_s;
    end else begin
      rd_key_dec_q <= {inv_mix_col(rd_word_s[127:96]), inv_mix_col(rd_word_s[95:64]),
                       inv_mix_col(rd_word_s[63:32]),  inv_mix_col(rd_word_s[31:0])};
    end
  end

  assign rd_key_dec = rd_key_dec_q;
`endif

  assign key_ready  = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander with one instance per key length.
// Expected round keys come from a behavioural key schedule whose S-box is
// derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start_v;
  logic [7:0]   key_in;
  logic         key_valid;
  logic [3:0]   rd_round;
  logic [2:0]   key_ready_v, busy_v, done_v, keys_valid_v;
  logic [127:0] rd_key_v [3];
`ifdef AES_KEYEXP_INVMIX_EN
  logic [127:0] rd_key_dec_v [3];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_expander #(.KEY_BITS(128 + 64 * g)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .key_in     (key_in),
      .key_valid  (key_valid),
      .key_ready  (key_ready_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .keys_valid (keys_valid_v[g]),
      .rd_round   (rd_round),
      .rd_key     (rd_key_v[g])
`ifdef AES_KEYEXP_INVMIX_EN
      ,
      .rd_key_dec (rd_key_dec_v[g])
`endif
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[v] = s;
    end
  endtask

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw_m(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int r, input int nr);
    if (r > nr) return 128'h0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_mix_m(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = k[127-32*c -: 8];
      a1 = k[119-32*c -: 8];
      a2 = k[111-32*c -: 8];
      a3 = k[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a read address, queue its expectation, compare one cycle later.
  task automatic rd_check(input int sel, input int r, input logic [127:0] exp, input string tag);
    rd_round = 4'(r);
    exp_q.push_back(exp);
    tick();
    chk(tag, rd_key_v[sel], exp_q.pop_front());
  endtask

`ifdef AES_KEYEXP_INVMIX_EN
  task automatic rd_dec_check(input int sel, input int r, input logic [127:0] exp, input string tag);
    rd_round = 4'(r);
    exp_q.push_back(exp);
    tick();
    chk(tag, rd_key_dec_v[sel], exp_q.pop_front());
  endtask
`endif

  task automatic load_key(input int sel, input logic [255:0] key, input bit gap,
                          input int nbytes, output int t0);
    start_v[sel] = 1'b1;
    t0 = cyc;
    tick();
    start_v[sel] = 1'b0;
    chk("load key_ready", 128'(key_ready_v[sel]), 128'd1);
    chk("load busy", 128'(busy_v[sel]), 128'd1);
    chk("load keys_valid", 128'(keys_valid_v[sel]), 128'd0);
    for (int j = 0; j < nbytes; j++) begin
      if (gap) begin
        key_valid = 1'b0;
        key_in    = 8'h00;
        tick();
      end
      key_in    = key[255-8*j -: 8];
      key_valid = 1'b1;
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int t0, input int exp_lat, input string tag);
    int n = 0;
    int kv_early = 0;
    while (done_v[sel] !== 1'b1 && n < 400) begin
      if (keys_valid_v[sel] !== 1'b0) kv_early++;
      tick();
      n++;
    end
    chk({tag, " done seen"}, 128'(done_v[sel]), 128'd1);
    chk({tag, " latency"}, 128'(cyc - t0), 128'(exp_lat));
    chk({tag, " keys_valid early"}, 128'(kv_early), 128'd0);
    chk({tag, " keys_valid"}, 128'(keys_valid_v[sel]), 128'd1);
    tick();
    chk({tag, " done pulse"}, 128'(done_v[sel]), 128'd0);
    chk({tag, " idle busy"}, 128'(busy_v[sel]), 128'd0);
    chk({tag, " ready key_ready"}, 128'(key_ready_v[sel]), 128'd0);
  endtask

  task automatic check_all(input int sel, input int nr, input string tag);
    for (int r = 0; r <= nr; r++) rd_check(sel, r, model_round(r, nr), $sformatf("%s r%0d", tag, r));
  endtask

  initial begin
    logic [255:0] k128, k192, k256, ka, kb;
    int t0;
    int dc;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    ka   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    kb   = {128'h3c4fcf098815f7aba6d2ae2816157e2b, 128'h0};

    rst = 1'b1; start_v = 3'b000; key_in = 8'h00; key_valid = 1'b0; rd_round = 4'd0;
    build_sbox();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset busy", 128'(busy_v), 128'd0);
    chk("reset key_ready", 128'(key_ready_v), 128'd0);
    chk("reset done", 128'(done_v), 128'd0);
    chk("reset keys_valid", 128'(keys_valid_v), 128'd0);
    chk("reset rd_key", rd_key_v[0], 128'h0);

    // AES-128 FIPS key, continuous stream
    model_expand(4, k128);
    load_key(0, k128, 1'b0, 16, t0);
    wait_done(0, t0, 57, "aes128");
    rd_check(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "aes128 r1 kat");
    rd_check(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128 r10 kat");
    rd_check(0, 11, 128'h0, "aes128 r11 oob");
    rd_check(0, 15, 128'h0, "aes128 r15 oob");
    check_all(0, 10, "aes128");
`ifdef AES_KEYEXP_INVMIX_EN
    rd_dec_check(0, 0, model_round(0, 10), "dec r0");
    rd_dec_check(0, 10, model_round(10, 10), "dec r10");
    rd_dec_check(0, 5, inv_mix_m(model_round(5, 10)), "dec r5");
    rd_dec_check(0, 1, inv_mix_m(model_round(1, 10)), "dec r1");
    rd_dec_check(0, 12, 128'h0, "dec r12 oob");
`endif

    // AES-192
    model_expand(6, k192);
    load_key(1, k192, 1'b0, 24, t0);
    wait_done(1, t0, 71, "aes192");
    rd_check(1, 12, 128'he98ba06f448c773c8ecc720401002202, "aes192 r12 kat");
    rd_check(1, 13, 128'h0, "aes192 r13 oob");
    check_all(1, 12, "aes192");

    // AES-256 with an idle cycle before every key byte
    model_expand(8, k256);
    load_key(2, k256, 1'b1, 32, t0);
    wait_done(2, t0, 117, "aes256");
    rd_check(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256 r14 kat");
    rd_check(2, 0, k256[255:128], "aes256 r0 key");
    check_all(2, 14, "aes256");

    // Abort during expansion, then a fresh 128-bit key
    dc = done_cnt[0];
    load_key(0, ka, 1'b0, 16, t0);
    repeat (10) tick();
    model_expand(4, kb);
    load_key(0, kb, 1'b0, 16, t0);
    rd_check(0, 1, 128'h0, "abort read while invalid");
    wait_done(0, t0, 57, "abort new");
    chk("abort done count", 128'(done_cnt[0] - dc), 128'd1);
    check_all(0, 10, "abort new");

    // Reset in the middle of a load
    load_key(0, ka, 1'b0, 7, t0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 128'(busy_v[0]), 128'd0);
    chk("midrst key_ready", 128'(key_ready_v[0]), 128'd0);
    chk("midrst keys_valid", 128'(keys_valid_v), 128'd0);
    chk("midrst rd_key", rd_key_v[0], 128'h0);
    model_expand(4, ka);
    load_key(0, ka, 1'b0, 16, t0);
    wait_done(0, t0, 57, "after rst");
    check_all(0, 10, "after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
